i2c_target: RTL

//  I2C responder (slave) that answers the synth's on-chip I2C master.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_sync_edge.sv | 31 +++
 rtl/i2c_target.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_REG_ADDR,
        ST_REG_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;
    localparam int   BYTE_BITS = 8;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes one async bus pin and reports its level, previous sample and edges.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic prev,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;

    // Reset to the idle-high bus level so no edge is seen right after reset on an idle bus.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/i2c_target.sv
// I2C target with a byte-wide register port: pointer write, burst write, burst read.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_data,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rd_data,
    output logic       busy
);

    logic scl_lvl, scl_prev, scl_rise, scl_fall;
    logic sda_lvl, sda_prev, sda_rise, sda_fall;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .clk(clk), .reset(reset), .pin(scl_i),
        .level(scl_lvl), .prev(scl_prev), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clk(clk), .reset(reset), .pin(sda_i),
        .level(sda_lvl), .prev(sda_prev), .rise(sda_rise), .fall(sda_fall)
    );

    state_t     state, state_next;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       rw;
    logic       wr_pend;

    logic start_det, stop_det, bus_cond;
    logic last_bit, rx_state, ack_state, addr_hit, load_rd;
    logic [7:0] byte_in;

    assign start_det = sda_fall & scl_lvl & scl_prev;
    assign stop_det  = sda_rise & scl_lvl & scl_prev;
    assign bus_cond  = start_det | stop_det;

    assign last_bit  = (bit_cnt == 3'(BYTE_BITS - 1));
    assign byte_in   = {shift[6:0], sda_lvl};
    assign addr_hit  = (byte_in[7:1] == DEV_ADDR) && (byte_in[7:1] != 7'h00);
    assign rx_state  = (state == ST_DEV_ADDR) || (state == ST_REG_ADDR) || (state == ST_WR_DATA);
    assign ack_state = (state == ST_DEV_ACK) || (state == ST_REG_ACK) || (state == ST_WR_ACK);

    // In an ACK state sda_oe doubles as the phase flag: set means the ACK bit is on the bus.
    assign load_rd = ~bus_cond & scl_fall &
                     (((state == ST_DEV_ACK) & sda_oe & (rw == I2C_READ)) | (state == ST_RD_ACK));

    assign reg_rd_en = load_rd;
    assign reg_wr_en = wr_pend & ~bus_cond;

    always_comb begin
        state_next = state;
        if (start_det) begin
            state_next = ST_DEV_ADDR;
        end else if (stop_det) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_DEV_ADDR: if (scl_rise && last_bit) state_next = addr_hit ? ST_DEV_ACK : ST_IGNORE;
                ST_DEV_ACK:  if (scl_fall && sda_oe)   state_next = (rw == I2C_READ) ? ST_RD_DATA : ST_REG_ADDR;
                ST_REG_ADDR: if (scl_rise && last_bit) state_next = ST_REG_ACK;
                ST_REG_ACK:  if (scl_fall && sda_oe)   state_next = ST_WR_DATA;
                ST_WR_DATA:  if (scl_rise && last_bit) state_next = ST_WR_ACK;
                ST_WR_ACK:   if (scl_fall && sda_oe)   state_next = ST_WR_DATA;
                ST_RD_DATA:  if (scl_fall && last_bit) state_next = ST_RD_ACK;
                ST_RD_ACK: begin
                    if (scl_rise && sda_lvl == I2C_NACK) state_next = ST_IGNORE;
                    else if (scl_fall)                   state_next = ST_RD_DATA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            rw          <= I2C_WRITE;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            wr_pend     <= 1'b0;
        end else begin
            state   <= state_next;
            wr_pend <= 1'b0;
            if (bus_cond) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                if (scl_rise && rx_state) begin
                    shift   <= byte_in;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (last_bit) begin
                        case (state)
                            ST_DEV_ADDR: if (addr_hit) begin
                                busy <= 1'b1;
                                rw   <= sda_lvl;
                            end
                            ST_REG_ADDR: reg_addr <= byte_in;
                            ST_WR_DATA: begin
                                wr_pend     <= 1'b1;
                                reg_wr_data <= byte_in;
                            end
                            default: ;
                        endcase
                    end
                end
                if (load_rd) begin
                    shift   <= reg_rd_data;
                    sda_oe  <= ~reg_rd_data[7];
                    bit_cnt <= '0;
                end else if (state == ST_RD_DATA && scl_fall) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (last_bit) begin
                        sda_oe   <= 1'b0;
                        reg_addr <= reg_addr + 8'd1;
                    end else begin
                        sda_oe <= ~shift[6];
                        shift  <= {shift[6:0], 1'b0};
                    end
                end else if (ack_state && scl_fall) begin
                    sda_oe <= ~sda_oe;
                    if (state == ST_WR_ACK && sda_oe) reg_addr <= reg_addr + 8'd1;
                end
                if (state == ST_RD_ACK && scl_rise && sda_lvl == I2C_NACK) busy <= 1'b0;
            end
        end
    end

endmodule
